n64a_vdemux: RTL and testbench
==============================

N64A_VDEMUX -- requirements
Module: n64a_vdemux

Interface
REQ-001 Parameter LOCK_CNT, default 8, number of consecutive good pixels needed to assert locked_o (range 1..15).
REQ-002 VCLK  input  1  video clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 nDSYNC  input  1  N64 data-sync strobe; low marks the sync-word cycle.
REQ-005 D_i  input  7  N64 multiplexed video bus.
REQ-006 video_data_o  output  25  assembled pixel {S[3:0], R[6:0], G[6:0], B[6:0]}, S = {nCSYNC, nHSYNC, nCLAMP, nVSYNC} = D_i[3:0] of sync cycle.
REQ-007 vdata_valid_o  output  1  one-cycle pulse, video_data_o just updated.
REQ-008 locked_o  output  1  demux phase locked to nDSYNC.
REQ-009 phase_err_o  output  1  one-cycle pulse on nDSYNC phase violation.

Function
REQ-010 FSM states WAIT_SYNC, GET_R, GET_G, GET_B; nominal sequence WAIT_SYNC -> GET_R -> GET_G -> GET_B -> WAIT_SYNC, period 4 VCLK.
REQ-011 Any state, nDSYNC low at edge: capture D_i[3:0] into sync holding register, next state GET_R.
REQ-012 GET_R / GET_G, nDSYNC high: capture D_i into R / G holding register, advance to GET_G / GET_B.
REQ-013 GET_B, nDSYNC high: at that edge video_data_o <= {sync_reg, R_reg, G_reg, D_i}, vdata_valid_o = 1 next cycle only, next state WAIT_SYNC with expect_sync flag set.
REQ-014 Latency: video_data_o and vdata_valid_o visible 1 VCLK after B-sample edge, i.e. stable before next nDSYNC-low edge of downstream gamma stage.
REQ-015 Early sync: nDSYNC low in GET_R, GET_G or GET_B -> partial pixel discarded, video_data_o unchanged, no valid pulse, phase_err_o pulse, new sync captured per REQ-011.
REQ-016 Late sync: WAIT_SYNC with expect_sync set and nDSYNC high -> phase_err_o pulse, expect_sync cleared, remain WAIT_SYNC; further high cycles produce no additional error.
REQ-017 WAIT_SYNC with expect_sync clear, nDSYNC high: idle, no error.
REQ-018 expect_sync cleared on any nDSYNC-low edge.
REQ-019 Good-pixel counter, 4 bits, saturating at LOCK_CNT: increments on each valid pixel; cleared on phase_err_o.
REQ-020 locked_o = 1 when counter == LOCK_CNT, registered; drops in same cycle phase_err_o asserts.
REQ-021 Output register holds last good pixel indefinitely when input stops.
REQ-022 Holding registers (sync/R/G) not cleared on error; overwritten before next use.

Reset
REQ-023 RST high asynchronously forces: state WAIT_SYNC, expect_sync 0, counter 0, holding registers 0, video_data_o 25'h0, vdata_valid_o 0, locked_o 0, phase_err_o 0.
REQ-024 RST mid-pixel discards partial pixel; after release, first nDSYNC-low edge starts clean capture, no phase_err_o for the aborted pixel.
REQ-025 No output changes while RST high regardless of nDSYNC/D_i.

Verification
REQ-026 Nominal: nDSYNC low with D_i=7'h0B, then 7'h12, 7'h34, 7'h56 -> next cycle video_data_o = {4'hB,7'h12,7'h34,7'h56}, vdata_valid_o one cycle.
REQ-027 Lock: 8 consecutive 4-cycle pixels -> locked_o rises 1 cycle after 8th valid pulse; 7 pixels -> locked_o stays 0.
REQ-028 Early sync: nDSYNC low during GET_G while locked -> phase_err_o pulse, locked_o 0, video_data_o keeps previous pixel, following good pixel assembles correctly.
REQ-029 Late sync: after GET_B, nDSYNC held high 3 cycles then low -> exactly one phase_err_o pulse, next pixel valid.
REQ-030 Reset: assert RST during GET_R after 8 locked pixels -> all outputs 0 immediately (no clock edge); after release, nominal pixel valid without phase_err_o.

Source files
------------

// File: rtl/n64a_vdemux.sv
// N64 video bus demultiplexer: assembles {sync, R, G, B} from the 4-phase multiplexed
// bus and tracks nDSYNC phase lock.
module n64a_vdemux #(
    parameter int unsigned LOCK_CNT = 8
) (
    input  logic        VCLK,
    input  logic        RST,
    input  logic        nDSYNC,
    input  logic [6:0]  D_i,
    output logic [24:0] video_data_o,
    output logic        vdata_valid_o,
    output logic        locked_o,
    output logic        phase_err_o
);

    localparam logic [3:0] LockCnt = 4'(LOCK_CNT);

    typedef enum logic [1:0] {StWaitSync, StGetR, StGetG, StGetB} state_e;

    state_e      state_q, state_d;
    logic        expect_sync_q, expect_sync_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  sync_q, sync_d;
    logic [6:0]  r_q, r_d;
    logic [6:0]  g_q, g_d;
    logic [24:0] video_q, video_d;
    logic        valid_q, valid_d;
    logic        perr_q, perr_d;
    logic        locked_q, locked_d;

    always_comb begin
        state_d       = state_q;
        expect_sync_d = expect_sync_q;
        sync_d        = sync_q;
        r_d           = r_q;
        g_d           = g_q;
        video_d       = video_q;
        valid_d       = 1'b0;
        perr_d        = 1'b0;

        if (!nDSYNC) begin
            // A sync strobe always restarts capture; mid-pixel it is an early-sync error.
            sync_d        = D_i[3:0];
            state_d       = StGetR;
            expect_sync_d = 1'b0;
            perr_d        = (state_q != StWaitSync);
        end else begin
            unique case (state_q)
                StWaitSync: begin
                    if (expect_sync_q) begin
                        perr_d        = 1'b1;
                        expect_sync_d = 1'b0;
                    end
                end
                StGetR: begin
                    r_d     = D_i;
                    state_d = StGetG;
                end
                StGetG: begin
                    g_d     = D_i;
                    state_d = StGetB;
                end
                StGetB: begin
                    video_d       = {sync_q, r_q, g_q, D_i};
                    valid_d       = 1'b1;
                    state_d       = StWaitSync;
                    expect_sync_d = 1'b1;
                end
                default: state_d = StWaitSync;
            endcase
        end

        cnt_d = cnt_q;
        if (perr_d) begin
            cnt_d = 4'd0;
        end else if (valid_d && (cnt_q < LockCnt)) begin
            cnt_d = cnt_q + 4'd1;
        end

        // Lock follows the registered count, but an error drops it on the same edge.
        locked_d = !perr_d && (cnt_q == LockCnt);
    end

    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            state_q       <= StWaitSync;
            expect_sync_q <= 1'b0;
            cnt_q         <= 4'd0;
            sync_q        <= 4'd0;
            r_q           <= 7'd0;
            g_q           <= 7'd0;
            video_q       <= 25'd0;
            valid_q       <= 1'b0;
            perr_q        <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            expect_sync_q <= expect_sync_d;
            cnt_q         <= cnt_d;
            sync_q        <= sync_d;
            r_q           <= r_d;
            g_q           <= g_d;
            video_q       <= video_d;
            valid_q       <= valid_d;
            perr_q        <= perr_d;
            locked_q      <= locked_d;
        end
    end

    assign video_data_o  = video_q;
    assign vdata_valid_o = valid_q;
    assign locked_o      = locked_q;
    assign phase_err_o   = perr_q;

endmodule

// File: tb/tb_n64a_vdemux.sv
// Scoreboard bench for n64a_vdemux: expected pixels queued on drive, popped on valid pulses.
module tb_n64a_vdemux;

    logic        VCLK = 1'b0;
    logic        RST;
    logic        nDSYNC;
    logic [6:0]  D_i;
    logic [24:0] video_data_o;
    logic        vdata_valid_o;
    logic        locked_o;
    logic        phase_err_o;

    int          errors = 0;
    int          checks = 0;
    int          perr_seen = 0;
    logic [24:0] exp_q[$];
    logic [24:0] mon_exp;

    n64a_vdemux #(.LOCK_CNT(8)) dut (
        .VCLK          (VCLK),
        .RST           (RST),
        .nDSYNC        (nDSYNC),
        .D_i           (D_i),
        .video_data_o  (video_data_o),
        .vdata_valid_o (vdata_valid_o),
        .locked_o      (locked_o),
        .phase_err_o   (phase_err_o)
    );

    always #5 VCLK = ~VCLK;

    always @(posedge VCLK) begin
        #2;
        if (phase_err_o === 1'b1) perr_seen++;
        if (vdata_valid_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got valid pixel %h, required no pulse", video_data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (video_data_o !== mon_exp) begin
                    errors++;
                    $display("FAIL scoreboard_pixel: got %h, required %h", video_data_o, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic step(input logic nd, input logic [6:0] d);
        @(negedge VCLK);
        nDSYNC = nd;
        D_i    = d;
    endtask

    task automatic settle();
        @(posedge VCLK);
        #3;
    endtask

    task automatic px_start(input logic [6:0] s);
        step(1'b0, s);
    endtask

    task automatic px_rest(input logic [6:0] s, input logic [6:0] r, input logic [6:0] g,
                           input logic [6:0] b);
        exp_q.push_back({s[3:0], r, g, b});
        step(1'b1, r);
        step(1'b1, g);
        step(1'b1, b);
    endtask

    task automatic px(input logic [6:0] s, input logic [6:0] r, input logic [6:0] g,
                      input logic [6:0] b);
        px_start(s);
        px_rest(s, r, g, b);
    endtask

    task automatic px_rand();
        logic [6:0] s, r, g, b;
        s = 7'($urandom);
        r = 7'($urandom);
        g = 7'($urandom);
        b = 7'($urandom);
        px(s, r, g, b);
    endtask

    task automatic reset_pulse();
        @(negedge VCLK);
        RST    = 1'b1;
        nDSYNC = 1'b1;
        @(negedge VCLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b0, 7'h0F);
        step(1'b1, 7'h7F);
        #1;
        checks += 4;
        if (video_data_o !== 25'h0) begin errors++; $display("FAIL reset_video: got %h, required 0", video_data_o); end
        if (vdata_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", vdata_valid_o); end
        if (locked_o !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b, required 0", locked_o); end
        if (phase_err_o !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b, required 0", phase_err_o); end
        @(negedge VCLK);
        RST    = 1'b0;
        nDSYNC = 1'b1;
    endtask

    task automatic test_nominal();
        int p;
        p = perr_seen;
        px(7'h0B, 7'h12, 7'h34, 7'h56);
        settle();
        checks += 3;
        if (vdata_valid_o !== 1'b1) begin errors++; $display("FAIL nominal_valid: got %b, required 1", vdata_valid_o); end
        if (video_data_o !== {4'hB, 7'h12, 7'h34, 7'h56}) begin errors++; $display("FAIL nominal_video: got %h, required %h", video_data_o, {4'hB, 7'h12, 7'h34, 7'h56}); end
        if (perr_seen != p) begin errors++; $display("FAIL nominal_perr: got %0d pulses, required 0", perr_seen - p); end
        step(1'b1, 7'h00);
        settle();
        checks += 2;
        if (vdata_valid_o !== 1'b0) begin errors++; $display("FAIL nominal_pulse_width: got %b, required 0", vdata_valid_o); end
        if (phase_err_o !== 1'b1) begin errors++; $display("FAIL idle_late_perr: got %b, required 1", phase_err_o); end
        repeat (3) step(1'b1, 7'h55);
        settle();
        checks += 2;
        if (video_data_o !== {4'hB, 7'h12, 7'h34, 7'h56}) begin errors++; $display("FAIL nominal_hold: got %h, required %h", video_data_o, {4'hB, 7'h12, 7'h34, 7'h56}); end
        if (perr_seen - p != 1) begin errors++; $display("FAIL idle_single_perr: got %0d pulses, required 1", perr_seen - p); end
    endtask

    task automatic test_lock();
        int p;
        reset_pulse();
        for (int i = 0; i < 7; i++) px_rand();
        px_start(7'h03);
        settle();
        checks++;
        if (locked_o !== 1'b0) begin errors++; $display("FAIL lock_after7: got %b, required 0", locked_o); end
        px_rest(7'h03, 7'h11, 7'h22, 7'h33);
        settle();
        checks += 2;
        if (vdata_valid_o !== 1'b1) begin errors++; $display("FAIL lock_8th_valid: got %b, required 1", vdata_valid_o); end
        if (locked_o !== 1'b0) begin errors++; $display("FAIL lock_early_rise: got %b, required 0", locked_o); end
        px_start(7'h0A);
        settle();
        checks += 2;
        if (locked_o !== 1'b1) begin errors++; $display("FAIL lock_rise: got %b, required 1", locked_o); end
        if (video_data_o !== {4'h3, 7'h11, 7'h22, 7'h33}) begin errors++; $display("FAIL lock_video: got %h, required %h", video_data_o, {4'h3, 7'h11, 7'h22, 7'h33}); end
        // Now in GET_R: reset lands asynchronously, between clock edges.
        RST = 1'b1;
        #1;
        checks += 4;
        if (video_data_o !== 25'h0) begin errors++; $display("FAIL async_rst_video: got %h, required 0", video_data_o); end
        if (vdata_valid_o !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b, required 0", vdata_valid_o); end
        if (locked_o !== 1'b0) begin errors++; $display("FAIL async_rst_locked: got %b, required 0", locked_o); end
        if (phase_err_o !== 1'b0) begin errors++; $display("FAIL async_rst_perr: got %b, required 0", phase_err_o); end
        step(1'b0, 7'h05);
        step(1'b1, 7'h7F);
        settle();
        checks += 2;
        if (video_data_o !== 25'h0) begin errors++; $display("FAIL rst_hold_video: got %h, required 0", video_data_o); end
        if (phase_err_o !== 1'b0) begin errors++; $display("FAIL rst_hold_perr: got %b, required 0", phase_err_o); end
        @(negedge VCLK);
        RST    = 1'b0;
        nDSYNC = 1'b1;
        p = perr_seen;
        px(7'h0B, 7'h12, 7'h34, 7'h56);
        settle();
        checks += 2;
        if (vdata_valid_o !== 1'b1) begin errors++; $display("FAIL post_rst_valid: got %b, required 1", vdata_valid_o); end
        if (perr_seen != p) begin errors++; $display("FAIL post_rst_perr: got %0d pulses, required 0", perr_seen - p); end
    endtask

    task automatic test_early_sync();
        reset_pulse();
        for (int i = 0; i < 7; i++) px_rand();
        px(7'h06, 7'h44, 7'h55, 7'h66);
        px_start(7'h01);
        step(1'b1, 7'h23);
        settle();
        checks++;
        if (locked_o !== 1'b1) begin errors++; $display("FAIL early_pre_locked: got %b, required 1", locked_o); end
        px_start(7'h09);
        settle();
        checks += 4;
        if (phase_err_o !== 1'b1) begin errors++; $display("FAIL early_perr: got %b, required 1", phase_err_o); end
        if (locked_o !== 1'b0) begin errors++; $display("FAIL early_unlock: got %b, required 0", locked_o); end
        if (vdata_valid_o !== 1'b0) begin errors++; $display("FAIL early_no_valid: got %b, required 0", vdata_valid_o); end
        if (video_data_o !== {4'h6, 7'h44, 7'h55, 7'h66}) begin errors++; $display("FAIL early_hold: got %h, required %h", video_data_o, {4'h6, 7'h44, 7'h55, 7'h66}); end
        px_rest(7'h09, 7'h1A, 7'h2B, 7'h3C);
        settle();
        checks += 2;
        if (vdata_valid_o !== 1'b1) begin errors++; $display("FAIL early_next_valid: got %b, required 1", vdata_valid_o); end
        if (video_data_o !== {4'h9, 7'h1A, 7'h2B, 7'h3C}) begin errors++; $display("FAIL early_next_video: got %h, required %h", video_data_o, {4'h9, 7'h1A, 7'h2B, 7'h3C}); end
    endtask

    task automatic test_late_sync();
        int p;
        reset_pulse();
        p = perr_seen;
        px(7'h0C, 7'h01, 7'h02, 7'h03);
        step(1'b1, 7'h00);
        settle();
        checks++;
        if (phase_err_o !== 1'b1) begin errors++; $display("FAIL late_perr: got %b, required 1", phase_err_o); end
        step(1'b1, 7'h00);
        settle();
        checks++;
        if (phase_err_o !== 1'b0) begin errors++; $display("FAIL late_second: got %b, required 0", phase_err_o); end
        step(1'b1, 7'h00);
        px(7'h0D, 7'h04, 7'h05, 7'h06);
        settle();
        checks += 2;
        if (vdata_valid_o !== 1'b1) begin errors++; $display("FAIL late_next_valid: got %b, required 1", vdata_valid_o); end
        if (perr_seen - p != 1) begin errors++; $display("FAIL late_pulse_count: got %0d pulses, required 1", perr_seen - p); end
    endtask

    task automatic test_back_to_back();
        int p;
        reset_pulse();
        p = perr_seen;
        for (int i = 0; i < 16; i++) px_rand();
        settle();
        checks += 3;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drained: got %0d pending, required 0", exp_q.size()); end
        if (perr_seen != p) begin errors++; $display("FAIL b2b_perr: got %0d pulses, required 0", perr_seen - p); end
        if (locked_o !== 1'b1) begin errors++; $display("FAIL b2b_locked: got %b, required 1", locked_o); end
    endtask

    initial begin
        RST    = 1'b1;
        nDSYNC = 1'b1;
        D_i    = 7'h00;
        test_reset();
        test_nominal();
        test_lock();
        test_early_sync();
        test_late_sync();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL final_drained: got %0d pending, required 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
